// File: rtl/ht_multi_cmd_frontend_pkg.sv
// Shared hash-table types, widths and the bucket XOR fold used by both the RTL and its reference model.
// Pure declarations: no latency, no flow control.
package hash_table;

  localparam int KEY_WIDTH     = 32;
  localparam int VALUE_WIDTH   = 16;
  localparam int BUCKET_WIDTH  = 8;
  localparam int PTR_WIDTH     = 16;
  localparam int MAX_CHANNELS  = 16;
  localparam int BUCKET_CHUNKS = (KEY_WIDTH + BUCKET_WIDTH - 1) / BUCKET_WIDTH;

  typedef enum logic [1:0] {
    OP_INIT   = 2'd0,
    OP_SEARCH = 2'd1,
    OP_INSERT = 2'd2,
    OP_DELETE = 2'd3
  } ht_opcode_t;

  typedef logic [$clog2(MAX_CHANNELS)-1:0] ht_chan_t;

  typedef struct packed {
    ht_opcode_t             op;
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
  } ht_command_t;

  typedef struct packed {
    ht_command_t             cmd;
    logic [BUCKET_WIDTH-1:0] bucket;
    logic [PTR_WIDTH-1:0]    head_ptr;
    logic                    head_ptr_val;
  } ht_pdata_t;

  typedef enum logic {
    BAR_OPEN = 1'b0,
    BAR_BUSY = 1'b1
  } bar_state_t;

  // Top chunk is zero-padded when KEY_WIDTH is not a multiple of BUCKET_WIDTH
  function automatic logic [BUCKET_WIDTH-1:0] calc_bucket(input logic [KEY_WIDTH-1:0] key);
    logic [BUCKET_CHUNKS*BUCKET_WIDTH-1:0] padded;
    logic [BUCKET_WIDTH-1:0]               acc;
    padded = (BUCKET_CHUNKS*BUCKET_WIDTH)'(key);
    acc    = '0;
    for (int i = 0; i < BUCKET_CHUNKS; i++) begin
      acc = acc ^ padded[i*BUCKET_WIDTH +: BUCKET_WIDTH];
    end
    return acc;
  endfunction

endpackage

// File: rtl/ht_multi_cmd_frontend_rr_arbiter.sv
// Round-robin arbiter: combinational grant searched from ptr_q; ptr_q moves past the grant on accept.
// Zero latency; the grant depends only on requests and ptr_q, never on accept, so no valid/ready loop.
module ht_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          accept_i,
  output logic [N-1:0]  grant_onehot_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          grant_vld_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cand;

  always_comb begin
    grant_onehot_o = '0;
    grant_idx_o    = '0;
    grant_vld_o    = 1'b0;
    cand           = ptr_q;
    for (int k = 0; k < N; k++) begin
      if (!grant_vld_o && req_i[cand]) begin
        grant_vld_o          = 1'b1;
        grant_idx_o          = cand;
        grant_onehot_o[cand] = 1'b1;
      end
      cand = (cand == IW'(N-1)) ? '0 : cand + IW'(1);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) begin
      ptr_d = (grant_idx_o == IW'(N-1)) ? '0 : grant_idx_o + IW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ht_multi_cmd_frontend.sv
// Hash-table command front-end: RR-arbitrates CHANNELS sources, folds key to bucket, HASH_STAGES-cycle pipe, OP_INIT barrier.
// A downstream stall freezes every stage and drops all cmd_ready_o; HT_FRONTEND_STATS_EN adds per-channel accept counters.
import hash_table::*;

module ht_multi_cmd_frontend #(
  parameter int CHANNELS    = 4,
  parameter int HASH_STAGES = 2,
  parameter int CW          = $clog2(CHANNELS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  ht_command_t [CHANNELS-1:0] cmd_i,
  input  logic [CHANNELS-1:0]       cmd_valid_i,
  output logic [CHANNELS-1:0]       cmd_ready_o,
  output ht_pdata_t                 pdata_o,
  output logic [CW-1:0]             pdata_chan_o,
  output logic                      pdata_valid_o,
  input  logic                      pdata_ready_i,
  input  logic                      init_done_i,
`ifdef HT_FRONTEND_STATS_EN
  input  logic                      stat_clr_i,
  output logic [CHANNELS-1:0][31:0] stat_accept_cnt_o,
`endif
  output logic                      init_busy_o
);

  logic                advance;
  logic                accept_ok;
  logic                accept;
  logic [CHANNELS-1:0] grant_onehot;
  logic [CW-1:0]       grant_idx;
  logic                grant_vld;
  ht_command_t         grant_cmd;

  bar_state_t bar_q, bar_d;

  ht_pdata_t              stage_dat_q  [HASH_STAGES];
  ht_pdata_t              stage_dat_d  [HASH_STAGES];
  logic [CW-1:0]          stage_chan_q [HASH_STAGES];
  logic [CW-1:0]          stage_chan_d [HASH_STAGES];
  logic [HASH_STAGES-1:0] stage_vld_q, stage_vld_d;

  assign advance     = !pdata_valid_o || pdata_ready_i;
  // rst_i in the gate keeps every ready low for the whole time reset is held
  assign accept_ok   = advance && !init_busy_o && rst_i;
  assign cmd_ready_o = accept_ok ? grant_onehot : '0;
  assign accept      = accept_ok && grant_vld;
  assign grant_cmd   = cmd_i[grant_idx];

  ht_rr_arbiter #(.N(CHANNELS), .IW(CW)) u_arb (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_i          (cmd_valid_i),
    .accept_i       (accept),
    .grant_onehot_o (grant_onehot),
    .grant_idx_o    (grant_idx),
    .grant_vld_o    (grant_vld)
  );

  // Done pulses while open are dropped; an INIT accept wins over a same-cycle done
  always_comb begin
    bar_d = bar_q;
    case (bar_q)
      BAR_OPEN: if (accept && grant_cmd.op == OP_INIT) bar_d = BAR_BUSY;
      BAR_BUSY: if (init_done_i) bar_d = BAR_OPEN;
      default:  bar_d = BAR_OPEN;
    endcase
  end

  always_comb begin
    stage_vld_d = stage_vld_q;
    for (int i = 0; i < HASH_STAGES; i++) begin
      stage_dat_d[i]  = stage_dat_q[i];
      stage_chan_d[i] = stage_chan_q[i];
    end
    if (advance) begin
      stage_vld_d[0] = accept;
      if (accept) begin
        stage_dat_d[0].cmd          = grant_cmd;
        stage_dat_d[0].bucket       = calc_bucket(grant_cmd.key);
        stage_dat_d[0].head_ptr     = '0;
        stage_dat_d[0].head_ptr_val = 1'b0;
        stage_chan_d[0]             = grant_idx;
      end
      for (int i = 1; i < HASH_STAGES; i++) begin
        stage_vld_d[i]  = stage_vld_q[i-1];
        stage_dat_d[i]  = stage_dat_q[i-1];
        stage_chan_d[i] = stage_chan_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bar_q       <= BAR_OPEN;
      stage_vld_q <= '0;
      for (int i = 0; i < HASH_STAGES; i++) begin
        stage_dat_q[i]  <= '0;
        stage_chan_q[i] <= '0;
      end
    end else begin
      bar_q       <= bar_d;
      stage_vld_q <= stage_vld_d;
      for (int i = 0; i < HASH_STAGES; i++) begin
        stage_dat_q[i]  <= stage_dat_d[i];
        stage_chan_q[i] <= stage_chan_d[i];
      end
    end
  end

  assign pdata_o       = stage_dat_q[HASH_STAGES-1];
  assign pdata_chan_o  = stage_chan_q[HASH_STAGES-1];
  assign pdata_valid_o = stage_vld_q[HASH_STAGES-1];
  assign init_busy_o   = (bar_q == BAR_BUSY);

`ifdef HT_FRONTEND_STATS_EN
  logic [CHANNELS-1:0][31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (stat_clr_i) begin
        cnt_d[c] = '0;
      end else if (cmd_ready_o[c] && cmd_valid_i[c] && cnt_q[c] != 32'hFFFF_FFFF) begin
        cnt_d[c] = cnt_q[c] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stat_accept_cnt_o = cnt_q;
`endif

endmodule
